// File: rtl/axis_usr_merge_framer_if.sv
// AXI4-Stream bundle carrying data, valid/ready, frame end and a sideband user word.
interface axis_usr_merge_framer_if #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned USER_W = 25
);
   logic              tvalid;
   logic              tready;
   logic [DATA_W-1:0] tdata;
   logic              tlast;
   logic [USER_W-1:0] tuser;

   // The upstream side only carries data; framing and tagging are produced by the block.
   modport master (output tvalid, output tdata, output tlast, output tuser, input tready);
   modport slave  (input tvalid, input tdata, output tready);
endinterface

// File: rtl/axis_usr_merge_framer.sv
// AXI4-Stream pass-through that tags each beat with {latched user word, beat index, tdata slice},
// frames the stream every FRAME_LENGTH beats and decouples ready through a 2-entry skid buffer.
module axis_usr_merge_framer #(
   parameter int unsigned AXIS_TDATA_WIDTH  = 32,
   parameter int unsigned USER_DATA_WIDTH   = 1,
   parameter int unsigned TDATA_SLICE_WIDTH = 16,
   parameter int unsigned CNTR_WIDTH        = 8,
   parameter int unsigned FRAME_LENGTH      = 256
) (
   input  logic                       aclk,
   input  logic                       aresetn,
   input  logic [USER_DATA_WIDTH-1:0] user_data,
   axis_usr_merge_framer_if.slave     s_axis,
   axis_usr_merge_framer_if.master    m_axis
);
   localparam int unsigned AXIS_TUSER_WIDTH = USER_DATA_WIDTH + CNTR_WIDTH + TDATA_SLICE_WIDTH;
   localparam logic [CNTR_WIDTH-1:0] LAST_IDX = CNTR_WIDTH'(FRAME_LENGTH - 1);

   logic                        ready_q, ready_d;
   logic [CNTR_WIDTH-1:0]       beat_idx_q, beat_idx_d;
   logic [USER_DATA_WIDTH-1:0]  usr_q, usr_d;
   logic                        out_valid_q, out_valid_d;
   logic [AXIS_TDATA_WIDTH-1:0] out_data_q, out_data_d;
   logic [AXIS_TUSER_WIDTH-1:0] out_user_q, out_user_d;
   logic                        out_last_q, out_last_d;
   logic                        skid_valid_q, skid_valid_d;
   logic [AXIS_TDATA_WIDTH-1:0] skid_data_q, skid_data_d;
   logic [AXIS_TUSER_WIDTH-1:0] skid_user_q, skid_user_d;
   logic                        skid_last_q, skid_last_d;

   logic                        accept;
   logic                        out_load;
   logic                        first_beat;
   logic [USER_DATA_WIDTH-1:0]  beat_usr;
   logic                        in_last;
   logic [AXIS_TUSER_WIDTH-1:0] in_user;

   // Tagging of the incoming beat from the current frame position.
   assign accept     = s_axis.tvalid & ready_q;
   assign out_load   = ~out_valid_q | m_axis.tready;
   assign first_beat = (beat_idx_q == '0);
   assign beat_usr   = first_beat ? user_data : usr_q;
   assign in_last    = (beat_idx_q == LAST_IDX);
   assign in_user    = {beat_usr, beat_idx_q, s_axis.tdata[TDATA_SLICE_WIDTH-1:0]};

   always_comb begin
      beat_idx_d   = beat_idx_q;
      usr_d        = usr_q;
      out_valid_d  = out_valid_q;
      out_data_d   = out_data_q;
      out_user_d   = out_user_q;
      out_last_d   = out_last_q;
      skid_valid_d = skid_valid_q;
      skid_data_d  = skid_data_q;
      skid_user_d  = skid_user_q;
      skid_last_d  = skid_last_q;

      if (accept) begin
         beat_idx_d = in_last ? '0 : beat_idx_q + 1'b1;
         if (first_beat) usr_d = user_data;
      end

      // ready_q is low whenever skid is full, so accept and skid drain never coincide.
      if (out_load) begin
         if (skid_valid_q) begin
            out_valid_d  = 1'b1;
            out_data_d   = skid_data_q;
            out_user_d   = skid_user_q;
            out_last_d   = skid_last_q;
            skid_valid_d = 1'b0;
         end else if (accept) begin
            out_valid_d = 1'b1;
            out_data_d  = s_axis.tdata;
            out_user_d  = in_user;
            out_last_d  = in_last;
         end else begin
            out_valid_d = 1'b0;
         end
      end else if (accept) begin
         skid_valid_d = 1'b1;
         skid_data_d  = s_axis.tdata;
         skid_user_d  = in_user;
         skid_last_d  = in_last;
      end

      ready_d = ~skid_valid_d;
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         ready_q      <= 1'b0;
         beat_idx_q   <= '0;
         usr_q        <= '0;
         out_valid_q  <= 1'b0;
         out_data_q   <= '0;
         out_user_q   <= '0;
         out_last_q   <= 1'b0;
         skid_valid_q <= 1'b0;
         skid_data_q  <= '0;
         skid_user_q  <= '0;
         skid_last_q  <= 1'b0;
      end else begin
         ready_q      <= ready_d;
         beat_idx_q   <= beat_idx_d;
         usr_q        <= usr_d;
         out_valid_q  <= out_valid_d;
         out_data_q   <= out_data_d;
         out_user_q   <= out_user_d;
         out_last_q   <= out_last_d;
         skid_valid_q <= skid_valid_d;
         skid_data_q  <= skid_data_d;
         skid_user_q  <= skid_user_d;
         skid_last_q  <= skid_last_d;
      end
   end

   assign s_axis.tready = ready_q;
   assign m_axis.tvalid = out_valid_q;
   assign m_axis.tdata  = out_data_q;
   assign m_axis.tuser  = out_user_q;
   assign m_axis.tlast  = out_last_q;
endmodule

// File: tb/tb_axis_usr_merge_framer.sv
// Directed and scoreboarded bench: FRAME_LENGTH=4 instance plus a FRAME_LENGTH=1 instance.
module tb_axis_usr_merge_framer;
   logic clk;
   logic aresetn;
   logic ud1;
   logic ud2;

   axis_usr_merge_framer_if #(.DATA_W(32), .USER_W(25)) s1 ();
   axis_usr_merge_framer_if #(.DATA_W(32), .USER_W(25)) m1 ();
   axis_usr_merge_framer_if #(.DATA_W(32), .USER_W(18)) s2 ();
   axis_usr_merge_framer_if #(.DATA_W(32), .USER_W(18)) m2 ();

   axis_usr_merge_framer #(.FRAME_LENGTH(4)) dut1 (
      .aclk(clk), .aresetn(aresetn), .user_data(ud1), .s_axis(s1), .m_axis(m1)
   );
   axis_usr_merge_framer #(.CNTR_WIDTH(1), .FRAME_LENGTH(1)) dut2 (
      .aclk(clk), .aresetn(aresetn), .user_data(ud2), .s_axis(s2), .m_axis(m2)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] d;
      logic        u;
      logic [24:0] tu;
      logic        l;
   } vec_t;

   typedef struct {
      logic [31:0] d;
      logic [24:0] tu;
      logic        l;
   } beat_t;

   vec_t  tv1[8];
   vec_t  tv2[4];
   beat_t sb[$];
   int    nvec;
   int    nerr;
   int    exp_idx;
   logic  exp_usr;
   logic [31:0] next_d;
   int    acc_cnt;
   logic  stall_prev;
   logic [57:0] held;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One cycle on dut1 with scoreboard tracking of accepts and output handshakes.
   task automatic cyc(input logic v, input logic u, input logic mr);
      beat_t b;
      s1.tvalid  = v;
      s1.tdata   = next_d;
      ud1        = u;
      m1.tready  = mr;
      if (stall_prev)
         chk("hold", 64'({m1.tvalid, m1.tdata, m1.tuser, m1.tlast}), 64'({1'b1, held}));
      if (v && s1.tready) begin
         if (exp_idx == 0) exp_usr = u;
         b.d  = next_d;
         b.tu = {exp_usr, 8'(exp_idx), next_d[15:0]};
         b.l  = (exp_idx == 3);
         sb.push_back(b);
         exp_idx = (exp_idx == 3) ? 0 : exp_idx + 1;
         next_d  = next_d + 32'd1;
         acc_cnt++;
      end
      if (m1.tvalid && mr) begin
         if (sb.size() == 0) begin
            chk("extra_beat", 64'(m1.tdata), 64'hFFFF_FFFF_FFFF_FFFF);
         end else begin
            b = sb.pop_front();
            chk("sb_beat", 64'({m1.tdata, m1.tuser, m1.tlast}), 64'({b.d, b.tu, b.l}));
         end
      end
      stall_prev = m1.tvalid && !mr;
      held = {m1.tdata, m1.tuser, m1.tlast};
      step();
   endtask

   initial begin
      int cycles;
      nvec = 0; nerr = 0; exp_idx = 0; exp_usr = 1'b0; next_d = 32'h0000_0100;
      acc_cnt = 0; stall_prev = 1'b0; held = '0;
      clk = 1'b0; aresetn = 1'b0;
      s1.tvalid = 1'b1; s1.tdata = 32'hDEAD_BEEF; s1.tlast = 1'b0; s1.tuser = '0;
      s2.tvalid = 1'b0; s2.tdata = '0; s2.tlast = 1'b0; s2.tuser = '0;
      m1.tready = 1'b1; m2.tready = 1'b1; ud1 = 1'b0; ud2 = 1'b0;

      tv1[0] = '{32'h00AB0010, 1'b0, 25'h0000010, 1'b0};
      tv1[1] = '{32'h00AB0011, 1'b0, 25'h0010011, 1'b0};
      tv1[2] = '{32'h00AB0012, 1'b1, 25'h0020012, 1'b0};
      tv1[3] = '{32'h00AB0013, 1'b1, 25'h0030013, 1'b1};
      tv1[4] = '{32'h00AB0014, 1'b1, 25'h1000014, 1'b0};
      tv1[5] = '{32'h00AB0015, 1'b1, 25'h1010015, 1'b0};
      tv1[6] = '{32'h00AB0016, 1'b1, 25'h1020016, 1'b0};
      tv1[7] = '{32'h00AB0017, 1'b1, 25'h1030017, 1'b1};
      tv2[0] = '{32'hCAFE0001, 1'b0, 25'h0000001, 1'b1};
      tv2[1] = '{32'hCAFE0002, 1'b1, 25'h0020002, 1'b1};
      tv2[2] = '{32'hCAFE0003, 1'b1, 25'h0020003, 1'b1};
      tv2[3] = '{32'hCAFE0004, 1'b0, 25'h0000004, 1'b1};

      // Reset held with valid asserted upstream.
      step(); step();
      chk("rst_s_ready", 64'(s1.tready), 64'd0);
      chk("rst_m_valid", 64'(m1.tvalid), 64'd0);
      chk("rst_tdata", 64'(m1.tdata), 64'd0);
      chk("rst_tuser", 64'(m1.tuser), 64'd0);
      chk("rst_tlast", 64'(m1.tlast), 64'd0);
      aresetn = 1'b1;
      #1;
      chk("rel_s_ready_pre", 64'(s1.tready), 64'd0);
      step();
      chk("rel_s_ready", 64'(s1.tready), 64'd1);
      chk("rel_m_valid", 64'(m1.tvalid), 64'd0);

      // Streaming table: one-cycle latency, frame tagging and user latch.
      for (int i = 0; i < 8; i++) begin
         s1.tvalid = 1'b1; s1.tdata = tv1[i].d; ud1 = tv1[i].u;
         chk($sformatf("stream_ready_%0d", i), 64'(s1.tready), 64'd1);
         step();
         chk($sformatf("stream_beat_%0d", i),
             64'({m1.tvalid, m1.tdata, m1.tuser, m1.tlast}),
             64'({1'b1, tv1[i].d, tv1[i].tu, tv1[i].l}));
      end
      s1.tvalid = 1'b0;
      step();
      chk("stream_idle", 64'(m1.tvalid), 64'd0);
      exp_idx = 0; exp_usr = 1'b1;

      // Backpressure: skid absorbs exactly two beats.
      acc_cnt = 0;
      cyc(1'b1, 1'b0, 1'b0);
      chk("bp_ready_c1", 64'(s1.tready), 64'd1);
      cyc(1'b1, 1'b0, 1'b0);
      chk("bp_ready_c2", 64'(s1.tready), 64'd0);
      cyc(1'b1, 1'b0, 1'b0);
      chk("bp_ready_c3", 64'(s1.tready), 64'd0);
      chk("bp_buffered", 64'(acc_cnt), 64'd2);
      for (int i = 0; i < 6; i++) begin
         cyc(1'b1, 1'b0, 1'b1);
         chk($sformatf("bp_nogap_%0d", i), 64'(m1.tvalid), 64'd1);
      end
      for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b1);
      chk("bp_drained", 64'(sb.size()), 64'd0);

      // Random backpressure and traffic over 1000 accepted beats.
      acc_cnt = 0; cycles = 0;
      while (acc_cnt < 1000 && cycles < 6000) begin
         cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
         cycles++;
      end
      chk("rand_accepted", 64'(acc_cnt), 64'd1000);
      cycles = 0;
      while ((sb.size() != 0 || m1.tvalid) && cycles < 20) begin
         cyc(1'b0, 1'b0, 1'b1);
         cycles++;
      end
      chk("rand_drained", 64'(sb.size()), 64'd0);

      // Async reset at beat_idx 2 with the frame's user word at 0.
      cycles = 0;
      while (exp_idx != 0 && cycles < 10) begin
         cyc(1'b1, 1'b0, 1'b1);
         cycles++;
      end
      cyc(1'b1, 1'b0, 1'b1);
      cyc(1'b1, 1'b0, 1'b1);
      chk("pre_rst_idx", 64'(exp_idx), 64'd2);
      s1.tvalid = 1'b0;
      #2;
      aresetn = 1'b0;
      #1;
      chk("arst_m_valid", 64'(m1.tvalid), 64'd0);
      chk("arst_tdata", 64'(m1.tdata), 64'd0);
      chk("arst_tuser", 64'(m1.tuser), 64'd0);
      chk("arst_s_ready", 64'(s1.tready), 64'd0);
      sb.delete(); exp_idx = 0; stall_prev = 1'b0;
      step();
      aresetn = 1'b1;
      step();
      chk("arst_rel_ready", 64'(s1.tready), 64'd1);
      cyc(1'b1, 1'b1, 1'b1);
      chk("arst_new_frame", 64'(m1.tuser[24:16]), 64'h100);
      cyc(1'b0, 1'b0, 1'b1);
      chk("arst_drained", 64'(sb.size()), 64'd0);

      // FRAME_LENGTH=1 instance: tlast every beat, index 0, user tracked per beat.
      for (int i = 0; i < 4; i++) begin
         s2.tvalid = 1'b1; s2.tdata = tv2[i].d; ud2 = tv2[i].u;
         step();
         chk($sformatf("f1_beat_%0d", i),
             64'({m2.tvalid, m2.tdata, m2.tuser, m2.tlast}),
             64'({1'b1, tv2[i].d, tv2[i].tu[17:0], tv2[i].l}));
      end
      s2.tvalid = 1'b0;
      step();

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule
